// File: rtl/spi_pkg.sv
// Constants and state encoding shared by the SPI master and the register-bank slave.
package spi_pkg;

   localparam logic [7:0] SLAVE_IDW = 8'h64;
   localparam logic [7:0] SLAVE_IDR = 8'h65;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ID     = 3'd1,
      S_ADDR   = 3'd2,
      S_WDATA  = 3'd3,
      S_RDATA  = 3'd4,
      S_IGNORE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, plus a history flop for edge detection.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic hist;

   // NOTE: non-blocking assignments keep the three stages a true shift chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         hist <= RST_VAL;
      end else begin
         meta <= pin;
         sync <= meta;
         hist <= sync;
      end
   end

   assign rise = sync & ~hist;
   assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave: decodes ID/address/data frames into a small register file and returns reads on miso.
module spi_slave_regs
   import spi_pkg::*;
#(
   parameter logic [7:0] SLAVE_IDW = spi_pkg::SLAVE_IDW,
   parameter logic [7:0] SLAVE_IDR = spi_pkg::SLAVE_IDR,
   parameter int         ADDR_W    = 4,
   parameter logic [7:0] RST_VAL   = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_valid,
   output logic       busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic ss_sync, ss_rise, ss_fall;
   logic sck_sync_unused, sck_rise, sck_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
      .clk(clk), .rst(rst), .pin(ss), .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .pin(sck), .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .pin(mosi), .sync(mosi_sync),
      .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   state_t     state;
   logic [2:0] bit_cnt;
   logic       rw;
   logic [6:0] shift;
   logic [7:0] addr;
   logic [7:0] tx_shift;
   logic       first_fall;
   logic [7:0] regs [DEPTH];
   logic [7:0] byte_in;

   // The byte as it stands once the current mosi bit is shifted in.
   assign byte_in = {shift, mosi_sync};
   assign busy    = (state != S_IDLE);

   function automatic logic in_range(input logic [7:0] a);
      return (a >> ADDR_W) == 8'd0;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         bit_cnt    <= 3'd0;
         rw         <= 1'b0;
         shift      <= 7'd0;
         addr       <= 8'd0;
         tx_shift   <= 8'd0;
         first_fall <= 1'b0;
         miso       <= 1'b0;
         wr_valid   <= 1'b0;
         wr_addr    <= 8'd0;
         wr_data    <= 8'd0;
         rd_valid   <= 1'b0;
         // NOTE: the register file is flops with a real reset, so a reset clears stored data.
         for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      end else begin
         wr_valid <= 1'b0;
         rd_valid <= 1'b0;
         // ss rising overrides everything, including a coincident 8th sck edge.
         if (ss_rise) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  miso <= 1'b0;
                  if (ss_fall) begin
                     bit_cnt <= 3'd0;
                     state   <= S_ID;
                  end
               end
               S_ID: if (sck_rise) begin
                  shift   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (byte_in == SLAVE_IDW) begin
                        rw    <= 1'b0;
                        state <= S_ADDR;
                     end else if (byte_in == SLAVE_IDR) begin
                        rw    <= 1'b1;
                        state <= S_ADDR;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end
               S_ADDR: if (sck_rise) begin
                  shift   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     addr <= byte_in;
                     if (rw) begin
                        tx_shift   <= in_range(byte_in) ? regs[byte_in[ADDR_W-1:0]] : 8'h00;
                        rd_valid   <= 1'b1;
                        first_fall <= 1'b1;
                        state      <= S_RDATA;
                     end else begin
                        state <= S_WDATA;
                     end
                  end
               end
               S_WDATA: if (sck_rise) begin
                  shift   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (in_range(addr)) regs[addr[ADDR_W-1:0]] <= byte_in;
                     wr_valid <= 1'b1;
                     wr_addr  <= addr;
                     wr_data  <= byte_in;
                     state    <= S_IGNORE;
                  end
               end
               S_RDATA: begin
                  if (sck_fall) begin
                     if (first_fall) begin
                        miso       <= tx_shift[7];
                        first_fall <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                     end
                  end
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        miso  <= 1'b0;
                        state <= S_IGNORE;
                     end
                  end
               end
               S_IGNORE: miso <= 1'b0;
               default: begin
                  miso  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI slave register bank that sits directly downstream of the team's SPI master. It consumes ss/sck/mosi and drives miso.
- Decodes the 3-byte frame the master issues: ID byte, address byte, data byte. ID 8'h64 selects a write; ID 8'h65 selects a read.
- Writes update a local register file. Reads shift the addressed register back on miso.
- SPI pins are oversampled in the clk domain.

Parameters:
- SLAVE_IDW, 8'h64, ID byte that selects a write frame.
- SLAVE_IDR, 8'h65, ID byte that selects a read frame.
- ADDR_W, 4, register file address width. The file holds 2**ADDR_W bytes.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; all logic is on posedge clk.
- rst  input  1  asynchronous, active-low reset.
- ss  input  1  slave select from the master, active low.
- sck  input  1  SPI clock from the master.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- wr_valid  output  1  one-clk pulse when a write commits.
- wr_addr  output  8  address of the committed write.
- wr_data  output  8  data of the committed write.
- rd_valid  output  1  one-clk pulse when read data is loaded for shifting.
- busy  output  1  high while ss is low (synchronised) and a frame is in progress.

Behaviour:
- Protocol:
  - SPI mode 0 (CPOL=0, CPHA=0), MSB first.
  - mosi is sampled on sck rising edges. miso changes on sck falling edges.
- Clock ratio requirement: each sck half-period lasts at least 4 clk cycles. Timing is not guaranteed below that ratio.
- Synchronisation:
  - ss, sck and mosi each pass through 2-flop synchronisers, followed by one history flop for edge detection.
  - ss synchronisers reset to 1. sck and mosi synchronisers reset to 0.
- Reset values: miso=0, wr_valid=0, wr_addr=0, wr_data=0, rd_valid=0, busy=0, state=S_IDLE, bit counter=0, all registers=RST_VAL.
- FSM states:
  - S_IDLE: wait for ss falling edge, then clear the bit counter and go to S_ID.
  - S_ID: shift 8 bits. After the 8th rising edge: ID==SLAVE_IDW or ID==SLAVE_IDR goes to S_ADDR and latches rw (0=write, 1=read); any other ID goes to S_IGNORE.
  - S_ADDR: shift 8 bits into addr.
    - After the 8th rising edge on a write frame: go to S_WDATA.
    - After the 8th rising edge on a read frame: load tx_shift with reg[addr], pulse rd_valid for 1 clk, go to S_RDATA.
  - S_WDATA: shift 8 bits. After the 8th rising edge, in the same clk:
    - write reg[addr[ADDR_W-1:0]] when addr < 2**ADDR_W;
    - pulse wr_valid for 1 clk with wr_addr=addr and wr_data=byte;
    - go to S_IGNORE.
  - S_RDATA:
    - On the first sck falling edge after entering (the falling edge of the address byte's 8th bit), miso = tx_shift[7].
    - On each subsequent falling edge, shift left and drive the next bit.
    - After 8 rising edges, go to S_IGNORE.
  - S_IGNORE: discard all sck activity and hold miso=0 until ss rises.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- ss rising edge in any state:
  - return to S_IDLE the next clk;
  - discard any partial byte (no write, no wr_valid);
  - miso=0.
- ss rising edge and 8th sck rising edge in the same clk: ss wins and the byte is discarded.
- Out-of-range address (addr >= 2**ADDR_W):
  - writes are not stored, but wr_valid still pulses;
  - reads return 8'h00.
- miso is 0 in every state except S_RDATA.
- busy = (state != S_IDLE).
- Bytes beyond the third in one ss window are ignored.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous). The frame is lost and the register file is cleared.

Decomposition:
- Shared package spi_pkg:
  - SLAVE_IDW and SLAVE_IDR constants, shared with the master;
  - FSM state encodings S_IDLE, S_ID, S_ADDR, S_WDATA, S_RDATA, S_IGNORE (3-bit).
- One sub-module, spi_sync_edge: 2-flop synchroniser plus history flop. It has a reset-value parameter and outputs sync, rise and fall. It is instantiated for ss, sck and mosi (rise/fall left unused for mosi).

Test Plan:
- Write frame, ss low, bytes 0x64, 0x03, 0xA5, ss high → one wr_valid pulse with wr_addr=0x03 and wr_data=0xA5; a following read returns 0xA5.
- Read frame 0x65, 0x03 after the above write → rd_valid pulses once after the address byte; miso carries 1,0,1,0,0,1,0,1 across the data byte; the master's rdata=0xA5.
- Bad ID 0x70, 0x03, 0xFF → no wr_valid; reg[3] unchanged; miso stays 0 for the whole frame.
- Abort: 0x64, 0x05, then 4 data bits, then ss high → no wr_valid; reg[5]=RST_VAL; the next full write to 0x05 with 0x3C succeeds.
- Out-of-range: with ADDR_W=4, write 0x20 with 0x77 → wr_valid pulses but no register changes; read of 0x20 → 0x00.
- Reset mid-frame: assert rst during the address byte → miso=0, busy=0, all registers 0x00; the next frame decodes correctly from its ID byte.
